top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameter data_width, default 8: RAM word width in bits, legal range 1..32.
REQ-002 Parameter ad_width, default 4: RAM address width in bits, legal range 1..12; depth N = 2^ad_width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request to run one memory self-test; level-sampled each cycle.
REQ-006 fail  output  1  registered; set when any read mismatch is detected in the current run.
REQ-007 done  output  1  registered; high while the controller sits in DONE.

Function
REQ-008 The block SHALL contain an internal N x data_width single-port RAM with combinational read and synchronous write.
REQ-009 The controller SHALL have states IDLE, M0, M1, M2, M3 and DONE, with one address operation per clock cycle.
REQ-010 In IDLE or DONE, start=1 SHALL, at that edge, clear fail and done, load address 0, and enter M0.
REQ-011 M0 SHALL run ascending from address 0 to N-1 and write all-zeros to each address.
REQ-012 M1 SHALL run ascending; at each address it SHALL read and expect all-zeros, then write all-ones in the same cycle.
REQ-013 M2 SHALL run descending from N-1 to 0; at each address it SHALL read and expect all-ones, then write all-zeros in the same cycle.
REQ-014 M3 SHALL run descending; at each address it SHALL read and expect all-zeros, with no write.
REQ-015 Each state SHALL advance to the next state after its final address, and M3 SHALL advance to DONE.
REQ-016 The transition M0->M1 SHALL load address 0, M1->M2 SHALL load N-1, and M2->M3 SHALL load N-1; the address SHALL never wrap within a state.
REQ-017 done SHALL rise exactly 4N cycles after the edge that sampled start (64 cycles for ad_width=4).
REQ-018 done SHALL stay high until reset or the next accepted start.
REQ-019 A mismatch SHALL set fail at the edge of the failing operation; fail SHALL be sticky, and the run SHALL continue to DONE.
REQ-020 A mismatch on the final M3 operation SHALL set fail at the same edge on which done rises.
REQ-021 start SHALL be ignored in states M0 to M3.
REQ-022 In DONE, start=1 SHALL restart the test, and done SHALL fall at that edge.

Reset
REQ-023 rst=1 at a clock edge SHALL force the state to IDLE, the address to 0, fail to 0 and done to 0, overriding start.
REQ-024 A reset during M0 to M3 SHALL abort the run without asserting done.
REQ-025 RAM contents SHALL NOT be reset.

Configuration
REQ-026 When macro TOP_FAULT_INJECT_EN is defined, RAM bit 0 of address N-1 SHALL read as constant 0 (stuck-at-0).
REQ-027 With TOP_FAULT_INJECT_EN defined, every run SHALL end with fail=1, first set during M2 at address N-1.
REQ-028 Without TOP_FAULT_INJECT_EN, the RAM SHALL be fault-free and every run SHALL end with fail=0.

Structure
REQ-029 Package top_pkg SHALL hold the state enum typedef (IDLE, M0, M1, M2, M3, DONE) and the element data patterns (zeros and ones).
REQ-030 The RAM SHALL be a sub-module top_ram, with parameters data_width and ad_width and ports clk, we, addr, wdata and rdata.
REQ-031 top SHALL contain the controller FSM, the address counter, the compare logic and the fail/done registers.

Verification (data_width=4, ad_width=4, N=16)
REQ-032 Hold rst=1 for 2 cycles, then release -> fail=0, done=0, state IDLE.
REQ-033 One-cycle start pulse -> done rises exactly 64 cycles later with fail=0, and stays high for 20 further idle cycles.
REQ-034 Pulse start while in DONE -> done falls at that edge and rises again 64 cycles later, fail=0.
REQ-035 Hold start high for the whole run -> exactly one run; done rises at cycle 64 and a restart occurs on the following edge.
REQ-036 Assert rst at cycle 30 of a run -> done and fail are 0 at the next edge; a new start then gives done after 64 cycles.
REQ-037 Build with TOP_FAULT_INJECT_EN and start -> fail rises at cycle 33 (M2, address 15) and done rises at cycle 64 with fail=1.

Source files
------------

// File: rtl/top_pkg.sv
// -----------------------------------------------------------------------------
// top_pkg
// Shared types and constants for the memory self-test block.
//   state_t    : controller states (IDLE, M0..M3, DONE)
//   ELEM_ZEROS : all-zeros data pattern (widest word; slice to data_width)
//   ELEM_ONES  : all-ones data pattern (widest word; slice to data_width)
// -----------------------------------------------------------------------------
package top_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      M0   = 3'd1,
      M1   = 3'd2,
      M2   = 3'd3,
      M3   = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam int unsigned MAX_DATA_WIDTH = 32;

   localparam logic [MAX_DATA_WIDTH-1:0] ELEM_ZEROS = 32'h0000_0000;
   localparam logic [MAX_DATA_WIDTH-1:0] ELEM_ONES  = 32'hFFFF_FFFF;

endpackage

// File: rtl/top_ram.sv
// -----------------------------------------------------------------------------
// top_ram
// Single-port RAM, 2^ad_width words of data_width bits.
// Combinational read, synchronous write. Contents are never reset.
//
// Ports:
//   clk   : clock, write on rising edge
//   we    : write enable
//   addr  : word address (read and write)
//   wdata : write data
//   rdata : read data (combinational from addr)
//
// Build option: TOP_FAULT_INJECT_EN makes bit 0 of the last address read
// back as a constant 0 (stuck-at-0), so the self-test has something to find.
// -----------------------------------------------------------------------------
module top_ram #(
   parameter int data_width = 8,
   parameter int ad_width   = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ad_width-1:0]   addr,
   input  logic [data_width-1:0] wdata,
   output logic [data_width-1:0] rdata
);

   logic [data_width-1:0] mem [0:(1<<ad_width)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

`ifdef TOP_FAULT_INJECT_EN
   always_comb begin
      rdata = mem[addr];
      if (addr == {ad_width{1'b1}}) begin
         rdata[0] = 1'b0;
      end
   end
`else
   assign rdata = mem[addr];
`endif

endmodule

// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top
// March-style memory self-test controller around an internal RAM.
// One accepted start runs four elements over every address, one address per
// clock, then parks in DONE with the result on fail.
//
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset
//   start : run request, level-sampled in IDLE/DONE, ignored while running
//   fail  : registered, sticky mismatch flag for the current run
//   done  : registered, high while in DONE
//
// Build option: TOP_FAULT_INJECT_EN (applied inside top_ram).
//
// state | meaning
// IDLE  | waiting for start after reset
// M0    | ascending, write zeros
// M1    | ascending, read expect zeros, write ones
// M2    | descending, read expect ones, write zeros
// M3    | descending, read expect zeros
// DONE  | run finished, done high, start restarts
// -----------------------------------------------------------------------------
module top #(
   parameter int data_width = 8,
   parameter int ad_width   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic fail,
   output logic done
);

   import top_pkg::*;

   localparam logic [data_width-1:0] PAT_ZEROS = ELEM_ZEROS[data_width-1:0];
   localparam logic [data_width-1:0] PAT_ONES  = ELEM_ONES[data_width-1:0];
   localparam logic [ad_width-1:0]   ADDR_LAST = {ad_width{1'b1}};

   state_t                state;
   logic [ad_width-1:0]   addr;
   logic                  we;
   logic [data_width-1:0] wdata;
   logic [data_width-1:0] rdata;
   logic [data_width-1:0] expect_data;
   logic                  check;
   logic                  mismatch;

   top_ram #(
      .data_width (data_width),
      .ad_width   (ad_width)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata)
   );

   // Per-element operation: the read (if any) sees the old word because the
   // RAM read is combinational and the write lands at the same edge.
   always_comb begin
      we          = 1'b0;
      wdata       = PAT_ZEROS;
      check       = 1'b0;
      expect_data = PAT_ZEROS;
      case (state)
         M0: begin
            we = 1'b1;
         end
         M1: begin
            check = 1'b1;
            we    = 1'b1;
            wdata = PAT_ONES;
         end
         M2: begin
            check       = 1'b1;
            expect_data = PAT_ONES;
            we          = 1'b1;
         end
         M3: begin
            check = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign mismatch = check && (rdata != expect_data);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addr  <= '0;
         fail  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= M0;
                  addr  <= '0;
                  fail  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            M0: begin
               if (addr == ADDR_LAST) begin
                  state <= M1;
                  addr  <= '0;
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            M1: begin
               fail <= fail | mismatch;
               if (addr == ADDR_LAST) begin
                  state <= M2;
                  addr  <= ADDR_LAST;
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            M2: begin
               fail <= fail | mismatch;
               if (addr == '0) begin
                  state <= M3;
                  addr  <= ADDR_LAST;
               end else begin
                  addr <= addr - 1'b1;
               end
            end
            M3: begin
               // A mismatch on the last read and done land on the same edge.
               fail <= fail | mismatch;
               if (addr == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  addr <= addr - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               addr  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top
// Self-checking bench for top (data_width=4, ad_width=4, N=16).
// Build with TOP_FAULT_INJECT_EN defined to exercise the stuck-at-0 case.
// -----------------------------------------------------------------------------
module tb_top;

   import top_pkg::*;

   localparam int DW  = 4;
   localparam int AW  = 4;
   localparam int N   = 16;
   localparam int RUN = 4 * N;

`ifdef TOP_FAULT_INJECT_EN
   localparam bit FAULT = 1'b1;
`else
   localparam bit FAULT = 1'b0;
`endif

   logic clk;
   logic rst;
   logic start;
   logic fail;
   logic done;

   int checks;
   int passed;

   top #(
      .data_width (DW),
      .ad_width   (AW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .fail  (fail),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model: the march algorithm run on a plain array gives, for each
   // cycle of a run, whether that cycle's read mismatches. A run is then just a
   // cycle counter from 0 to 4N.
   // ---------------------------------------------------------------------------
   bit fail_step [0:RUN];
   bit m_run;
   bit m_done;
   bit m_fail;
   int m_cnt;
   bit chk_en;

   function automatic logic [DW-1:0] model_read(input logic [DW-1:0] mem_m [N], input int a);
      logic [DW-1:0] v;
      v = mem_m[a];
      if (FAULT && a == N - 1) v[0] = 1'b0;
      return v;
   endfunction

   initial begin
      logic [DW-1:0] mem_m [N];
      logic [DW-1:0] ones;
      logic [DW-1:0] exp_v;
      int c;
      int a;
      ones = '1;
      for (int i = 0; i < N; i++) mem_m[i] = $urandom_range(0, (1 << DW) - 1);
      for (int i = 0; i <= RUN; i++) fail_step[i] = 1'b0;
      c = 0;
      for (int el = 0; el < 4; el++) begin
         for (int k = 0; k < N; k++) begin
            a = (el < 2) ? k : N - 1 - k;
            c++;
            if (el > 0) begin
               exp_v = (el == 2) ? ones : '0;
               fail_step[c] = (model_read(mem_m, a) != exp_v);
            end
            if (el < 3) mem_m[a] = (el == 1) ? ones : '0;
         end
      end
   end

   initial begin
      m_run  = 1'b0;
      m_done = 1'b0;
      m_fail = 1'b0;
      m_cnt  = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_run  <= 1'b0;
         m_done <= 1'b0;
         m_fail <= 1'b0;
      end else if (!m_run && start) begin
         m_run  <= 1'b1;
         m_cnt  <= 0;
         m_fail <= 1'b0;
         m_done <= 1'b0;
      end else if (m_run) begin
         m_cnt <= m_cnt + 1;
         if (fail_step[m_cnt + 1]) m_fail <= 1'b1;
         if (m_cnt + 1 == RUN) begin
            m_run  <= 1'b0;
            m_done <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (done !== m_done || fail !== m_fail) begin
            $display("FAIL model_cycle t=%0t: done=%b fail=%b, required done=%b fail=%b",
                     $time, done, fail, m_done, m_fail);
         end else begin
            passed++;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
      end else begin
         passed++;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scenario table. Cycle numbers count edges from the edge that samples the
   // first start (edge 0); -1 means "never within the budget".
   // ---------------------------------------------------------------------------
   typedef struct {
      string name;
      int    start_len;
      int    extra_start;
      int    rst_at;
      int    budget;
      int    exp_done;
      int    exp_fail_cyc;
      bit    exp_done_end;
      bit    exp_fail_end;
   } vec_t;

   vec_t vecs [6];

   task automatic run_vec(input vec_t v);
      int done_cyc;
      int fail_cyc;
      int done_at0;
      done_cyc = -1;
      fail_cyc = -1;
      done_at0 = -1;
      for (int cyc = 0; cyc <= v.budget; cyc++) begin
         start = (cyc < v.start_len) || (cyc == v.extra_start);
         rst   = (cyc == v.rst_at);
         @(posedge clk);
         #1;
         if (cyc == 0) done_at0 = int'(done);
         if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
         if (fail === 1'b1 && fail_cyc < 0) fail_cyc = cyc;
      end
      rst = 1'b0;
      chk({v.name, "_done_at_start_edge"}, done_at0, 0);
      chk({v.name, "_done_cycle"}, done_cyc, v.exp_done);
      chk({v.name, "_first_fail_cycle"}, fail_cyc, v.exp_fail_cyc);
      chk({v.name, "_done_end"}, int'(done), int'(v.exp_done_end));
      chk({v.name, "_fail_end"}, int'(fail), int'(v.exp_fail_end));
   endtask

   initial begin
      int ff;
      checks = 0;
      passed = 0;
      chk_en = 1'b0;
      ff     = FAULT ? 33 : -1;

      vecs[0] = '{"single_pulse",      1,    -1, -1, RUN + 20, RUN, ff, 1'b1, FAULT};
      vecs[1] = '{"restart_from_done", 1,    -1, -1, RUN + 6,  RUN, ff, 1'b1, FAULT};
      vecs[2] = '{"ignore_mid_start",  1,    10, -1, RUN + 6,  RUN, ff, 1'b1, FAULT};
      vecs[3] = '{"reset_mid_run",     1,    -1, 30, 100,      -1,  -1, 1'b0, 1'b0};
      vecs[4] = '{"start_after_reset", 1,    -1, -1, RUN + 6,  RUN, ff, 1'b1, FAULT};
      vecs[5] = '{"hold_start",        1000, -1, -1, RUN,      RUN, ff, 1'b1, FAULT};

      rst   = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_fail", int'(fail), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_state_idle", int'(dut.state == IDLE), 1);
      @(negedge clk);
      chk_en = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // start still held after hold_start: the edge after done restarts.
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_restart_done_falls", int'(done), 0);
      chk("hold_restart_state_m0", int'(dut.state == M0), 1);

      // Reset overrides a simultaneous start.
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_over_start_state", int'(dut.state == IDLE), 1);
      chk("rst_over_start_done", int'(done), 0);
      rst   = 1'b0;
      start = 1'b0;

      // Random start/reset traffic; the negedge model compare does the checking.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 24) == 0);
         rst   = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      repeat (RUN + 4) @(negedge clk);
      chk("drain_done_or_idle", int'(done === m_done), 1);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
